tcm_port_arbiter: RTL and testbench

- Parametrised successor to the single-external-port TCM arrangement.
- Arbitrates NUM_PORTS independent ram-style requestors onto one single-port synchronous TCM RAM. Typical requestors are the core data port, one or more AXI-to-RAM bridges, and a DMA.
- Supports fixed-priority or round-robin arbitration, an anti-starvation timer, configurable RAM read latency and out-of-range error responses.

---
 rtl/tcm_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_tcm_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_port_arbiter.sv
// Arbitrates NUM_PORTS ram-style requestors onto one single-port synchronous TCM.
// Grant and RAM drive are combinational; responses return RAM_LAT cycles after accept.
module tcm_port_arbiter #(
   parameter int NUM_PORTS = 3,
   parameter int ADDR_W    = 32,
   parameter int TCM_BYTES = 65536,
   parameter int ARB_MODE  = 0,
   parameter int MAX_WAIT  = 15,
   parameter int RAM_LAT   = 1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NUM_PORTS-1:0]          req_rd_i,
   input  logic [4*NUM_PORTS-1:0]        req_wr_i,
   input  logic [ADDR_W*NUM_PORTS-1:0]   req_addr_i,
   input  logic [32*NUM_PORTS-1:0]       req_wdata_i,
   output logic [NUM_PORTS-1:0]          req_accept_o,
   output logic [NUM_PORTS-1:0]          req_ack_o,
   output logic                          req_err_o,
   output logic [31:0]                   req_rdata_o,
   output logic                          ram_en_o,
   output logic [3:0]                    ram_we_o,
   output logic [$clog2(TCM_BYTES)-3:0]  ram_addr_o,
   output logic [31:0]                   ram_wdata_o,
   input  logic [31:0]                   ram_rdata_i
);

   localparam int TCM_AW = $clog2(TCM_BYTES);
   localparam int PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

   typedef struct packed {
      logic          vld;
      logic [PW-1:0] port;
      logic          err;
      logic          rd;
   } rsp_t;

   logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
   logic [NUM_PORTS-1:0][3:0]        wr;
   logic [NUM_PORTS-1:0][31:0]       wdata;
   logic [NUM_PORTS-1:0]             req;
   logic [NUM_PORTS-1:0]             expired;

   logic [NUM_PORTS-1:0][WAIT_W-1:0] wait_q, wait_d;
   logic [PW-1:0]                    last_q, last_d;
   rsp_t [RAM_LAT-1:0]               pipe_q, pipe_d;

   logic              gnt_vld;
   logic [PW-1:0]     gnt_idx;
   logic [ADDR_W-1:0] sel_addr;
   logic              in_range;
   logic              is_wr;
   logic              unused_addr_lsb;
   rsp_t              rsp;
   logic              ack_vld;

   assign addr  = req_addr_i;
   assign wr    = req_wr_i;
   assign wdata = req_wdata_i;

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         req[p]     = req_rd_i[p] | (|wr[p]);
         expired[p] = (MAX_WAIT != 0) && (wait_q[p] == WAIT_W'(MAX_WAIT));
      end
   end

   // Each scan runs high-to-low so the last hit is the lowest index; the second
   // scan only overrides the first when a higher-priority candidate exists.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int i = NUM_PORTS-1; i >= 0; i--) begin
         if (req[i]) begin
            gnt_vld = 1'b1;
            gnt_idx = PW'(i);
         end
      end
      for (int i = NUM_PORTS-1; i >= 0; i--) begin
         if (ARB_MODE == 1) begin
            if (req[i] && (PW'(i) > last_q)) gnt_idx = PW'(i);
         end else begin
            if (req[i] && expired[i]) gnt_idx = PW'(i);
         end
      end
      if (!rst_ni) gnt_vld = 1'b0;
   end

   always_comb begin
      sel_addr = addr[gnt_idx];
      is_wr    = |wr[gnt_idx];
      in_range = 1'b1;
      for (int b = TCM_AW; b < ADDR_W; b++) begin
         if (sel_addr[b]) in_range = 1'b0;
      end
   end

   assign unused_addr_lsb = ^sel_addr[1:0];

   always_comb begin
      req_accept_o = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         req_accept_o[p] = gnt_vld && (gnt_idx == PW'(p));
      end
      ram_en_o    = gnt_vld && in_range;
      ram_we_o    = ram_en_o ? wr[gnt_idx] : 4'b0;
      ram_addr_o  = ram_en_o ? sel_addr[TCM_AW-1:2] : '0;
      ram_wdata_o = ram_en_o ? wdata[gnt_idx] : 32'b0;
   end

   always_comb begin
      wait_d = wait_q;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (gnt_vld && (gnt_idx == PW'(p)))
            wait_d[p] = '0;
         else if (req[p] && (wait_q[p] != WAIT_W'(MAX_WAIT)))
            wait_d[p] = wait_q[p] + 1'b1;
      end
      last_d = gnt_vld ? gnt_idx : last_q;
   end

   always_comb begin
      pipe_d[0].vld  = gnt_vld;
      pipe_d[0].port = gnt_idx;
      pipe_d[0].err  = !in_range;
      pipe_d[0].rd   = !is_wr;
      for (int s = 1; s < RAM_LAT; s++) pipe_d[s] = pipe_q[s-1];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wait_q <= '0;
         last_q <= PW'(NUM_PORTS - 1);
         pipe_q <= '0;
      end else begin
         wait_q <= wait_d;
         last_q <= last_d;
         pipe_q <= pipe_d;
      end
   end

   // Responses still in the pipe while reset is low must not surface.
   always_comb begin
      rsp       = pipe_q[RAM_LAT-1];
      ack_vld   = rsp.vld && rst_ni;
      req_ack_o = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         req_ack_o[p] = ack_vld && (rsp.port == PW'(p));
      end
      req_err_o   = ack_vld && rsp.err;
      req_rdata_o = (ack_vld && !rsp.err && rsp.rd) ? ram_rdata_i : 32'b0;
   end

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Directed bench: RR, fixed-priority with starvation timer, and RAM_LAT=2 instances
// share one set of request inputs; each has its own behavioural RAM.
module tb_tcm_port_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   logic [2:0]       rd;
   logic [2:0][3:0]  wr;
   logic [2:0][31:0] addr;
   logic [2:0][31:0] wdata;

   logic [2:0]  acc       [3];
   logic [2:0]  ack       [3];
   logic        err       [3];
   logic [31:0] rdata     [3];
   logic        ram_en    [3];
   logic [3:0]  ram_we    [3];
   logic [13:0] ram_addr  [3];
   logic [31:0] ram_wdata [3];
   logic [31:0] ram_rdata [3];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   tcm_port_arbiter #(.ARB_MODE(1), .RAM_LAT(1)) u_rr (
      .clk_i(clk), .rst_ni(rst_n), .req_rd_i(rd), .req_wr_i(wr), .req_addr_i(addr),
      .req_wdata_i(wdata), .req_accept_o(acc[0]), .req_ack_o(ack[0]), .req_err_o(err[0]),
      .req_rdata_o(rdata[0]), .ram_en_o(ram_en[0]), .ram_we_o(ram_we[0]),
      .ram_addr_o(ram_addr[0]), .ram_wdata_o(ram_wdata[0]), .ram_rdata_i(ram_rdata[0]));

   tcm_port_arbiter #(.ARB_MODE(0), .MAX_WAIT(3), .RAM_LAT(1)) u_fx (
      .clk_i(clk), .rst_ni(rst_n), .req_rd_i(rd), .req_wr_i(wr), .req_addr_i(addr),
      .req_wdata_i(wdata), .req_accept_o(acc[1]), .req_ack_o(ack[1]), .req_err_o(err[1]),
      .req_rdata_o(rdata[1]), .ram_en_o(ram_en[1]), .ram_we_o(ram_we[1]),
      .ram_addr_o(ram_addr[1]), .ram_wdata_o(ram_wdata[1]), .ram_rdata_i(ram_rdata[1]));

   tcm_port_arbiter #(.ARB_MODE(0), .RAM_LAT(2)) u_l2 (
      .clk_i(clk), .rst_ni(rst_n), .req_rd_i(rd), .req_wr_i(wr), .req_addr_i(addr),
      .req_wdata_i(wdata), .req_accept_o(acc[2]), .req_ack_o(ack[2]), .req_err_o(err[2]),
      .req_rdata_o(rdata[2]), .ram_en_o(ram_en[2]), .ram_we_o(ram_we[2]),
      .ram_addr_o(ram_addr[2]), .ram_wdata_o(ram_wdata[2]), .ram_rdata_i(ram_rdata[2]));

   // Word i holds C0DE0000+i, except word 16 which starts at zero.
   for (genvar k = 0; k < 3; k++) begin : g_ram
      localparam int LAT = (k == 2) ? 2 : 1;
      logic [31:0] mem [16384];
      logic [31:0] q1 = '0;
      logic [31:0] q2 = '0;
      initial begin
         for (int i = 0; i < 16384; i++) mem[i] = 32'hC0DE_0000 + i;
         mem[16] = '0;
      end
      always @(posedge clk) begin
         if (ram_en[k]) begin
            for (int b = 0; b < 4; b++)
               if (ram_we[k][b]) mem[ram_addr[k]][8*b +: 8] <= ram_wdata[k][8*b +: 8];
            q1 <= mem[ram_addr[k]];
         end
         q2 <= q1;
      end
      assign ram_rdata[k] = (LAT == 2) ? q2 : q1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rd = '0; wr = '0; addr = '0; wdata = '0;
   endtask

   task automatic do_reset();
      cyc();
      rst_n = 1'b0;
      idle();
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      rd = 3'b111;
      addr[1] = 32'h100;
      addr[2] = 32'h200;
      cyc();
      cyc();
      #2;
      chk("rst_acc",    32'(acc[0]), 32'h0);
      chk("rst_ram_en", 32'(ram_en[0]), 32'h0);
      chk("rst_ack",    32'(ack[0]), 32'h0);
      chk("rst_err",    32'(err[0]), 32'h0);
      chk("rst_rdata",  rdata[0], 32'h0);
      chk("rst_we",     32'(ram_we[0]), 32'h0);
      chk("rst_fx_acc", 32'(acc[1]), 32'h0);

      // Round-robin, all three reading continuously.
      do_reset();
      rd = 3'b111; addr[0] = 32'h0; addr[1] = 32'h100; addr[2] = 32'h200;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) cyc();
         #2;
         chk("rr_acc",   32'(acc[0]), 32'(1 << (i % 3)));
         chk("rr_raddr", 32'(ram_addr[0]), 32'((i % 3) * 64));
         if (i > 0) begin
            chk("rr_ack",   32'(ack[0]), 32'(1 << ((i - 1) % 3)));
            chk("rr_rdata", rdata[0], 32'hC0DE_0000 + 32'(((i - 1) % 3) * 64));
         end
      end

      // Fixed priority, MAX_WAIT=3: port 2 forced in every 4th cycle.
      do_reset();
      rd = 3'b101; addr[0] = 32'h0; addr[2] = 32'h200;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) cyc();
         #2;
         chk("fx_acc", 32'(acc[1]), (i % 4 == 3) ? 32'h4 : 32'h1);
      end

      // Partial write then read-back on port 1.
      do_reset();
      wr[1] = 4'b0011; addr[1] = 32'h40; wdata[1] = 32'hDEAD_BEEF;
      #2;
      chk("wr_acc",   32'(acc[0]), 32'h2);
      chk("wr_en",    32'(ram_en[0]), 32'h1);
      chk("wr_we",    32'(ram_we[0]), 32'h3);
      chk("wr_addr",  32'(ram_addr[0]), 32'h10);
      chk("wr_wdata", ram_wdata[0], 32'hDEAD_BEEF);
      cyc();
      wr[1] = 4'b0; rd[1] = 1'b1;
      #2;
      chk("rdb_acc",    32'(acc[0]), 32'h2);
      chk("rdb_we",     32'(ram_we[0]), 32'h0);
      chk("wr_ack",     32'(ack[0]), 32'h2);
      chk("wr_ack_err", 32'(err[0]), 32'h0);
      chk("wr_rdata",   rdata[0], 32'h0);
      cyc();
      rd = '0;
      #2;
      chk("rdb_ack",   32'(ack[0]), 32'h2);
      chk("rdb_rdata", rdata[0], 32'h0000_BEEF);
      chk("rdb_err",   32'(err[0]), 32'h0);

      // Out-of-range read on port 0.
      cyc();
      rd[0] = 1'b1; addr[0] = 32'h0001_0000;
      #2;
      chk("oor_acc",    32'(acc[0]), 32'h1);
      chk("oor_ram_en", 32'(ram_en[0]), 32'h0);
      cyc();
      rd = '0; addr = '0;
      #2;
      chk("oor_ack",   32'(ack[0]), 32'h1);
      chk("oor_err",   32'(err[0]), 32'h1);
      chk("oor_rdata", rdata[0], 32'h0);

      // RAM_LAT=2, back-to-back reads by ports 0,1,0.
      do_reset();
      rd = 3'b001; addr[0] = 32'h0;
      #2;
      chk("l2_acc0", 32'(acc[2]), 32'h1);
      cyc();
      rd = 3'b010; addr[1] = 32'h100;
      #2;
      chk("l2_acc1",  32'(acc[2]), 32'h2);
      chk("l2_noack", 32'(ack[2]), 32'h0);
      cyc();
      rd = 3'b001; addr[0] = 32'h8;
      #2;
      chk("l2_acc2",   32'(acc[2]), 32'h1);
      chk("l2_ack0",   32'(ack[2]), 32'h1);
      chk("l2_rdata0", rdata[2], 32'hC0DE_0000);
      cyc();
      rd = '0;
      #2;
      chk("l2_ack1",   32'(ack[2]), 32'h2);
      chk("l2_rdata1", rdata[2], 32'hC0DE_0040);
      cyc();
      #2;
      chk("l2_ack2",   32'(ack[2]), 32'h1);
      chk("l2_rdata2", rdata[2], 32'hC0DE_0002);

      // Reset with responses in flight; RR restarts at port 0.
      do_reset();
      rd = 3'b111; addr[0] = 32'h0; addr[1] = 32'h100; addr[2] = 32'h200;
      #2;
      chk("fl_acc0", 32'(acc[0]), 32'h1);
      cyc();
      #2;
      chk("fl_acc1", 32'(acc[0]), 32'h2);
      cyc();
      rst_n = 1'b0;
      #2;
      chk("fl_rr_ack",   32'(ack[0]), 32'h0);
      chk("fl_l2_ack",   32'(ack[2]), 32'h0);
      chk("fl_acc_rst",  32'(acc[0]), 32'h0);
      chk("fl_en_rst",   32'(ram_en[0]), 32'h0);
      chk("fl_rdata",    rdata[0], 32'h0);
      chk("fl_l2_rdata", rdata[2], 32'h0);
      cyc();
      #2;
      chk("fl_l2_ack2", 32'(ack[2]), 32'h0);
      chk("fl_rr_ack2", 32'(ack[0]), 32'h0);
      cyc();
      rst_n = 1'b1;
      #2;
      chk("fl_restart", 32'(acc[0]), 32'h1);
      cyc();
      #2;
      chk("fl_post_ack",   32'(ack[0]), 32'h1);
      chk("fl_post_rdata", rdata[0], 32'hC0DE_0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
